// File: rtl/step_move_sched_pkg.sv
// step_move_sched_pkg -- shared FSM encoding, idle dwell code and step-count width
// Rev 1.0
`default_nettype none

package step_move_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0] c_idle_dwell = 4'hF;
  localparam int         c_step_w     = 16;

endpackage

`default_nettype wire

// File: rtl/step_stall_wdt.sv
// step_stall_wdt -- 1 ms timebase plus stall watchdog, restarted by every step event
// Rev 1.0
`default_nettype none

module step_stall_wdt #(
  parameter logic [15:0] T1MS     = 16'd49999,
  parameter logic [7:0]  STALL_MS = 8'd100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_step,
  output logic o_stall
);

  logic [15:0] r_cyc;
  logic [7:0]  r_ms;
  logic        w_tick;

  assign w_tick  = (r_cyc == T1MS);
  // The ms tick that completes the STALL_MS-th idle millisecond raises the fault.
  assign o_stall = i_run && !i_step && w_tick && (r_ms == (STALL_MS - 8'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc <= 16'd0;
      r_ms  <= 8'd0;
    end else if (!i_run || i_step) begin
      r_cyc <= 16'd0;
      r_ms  <= 8'd0;
    end else if (w_tick) begin
      r_cyc <= 16'd0;
      r_ms  <= r_ms + 8'd1;
    end else begin
      r_cyc <= r_cyc + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/step_move_sched.sv
// step_move_sched -- stepper move scheduler: command capture, step counting, abort/stall fault
// Optional macro RAMP_EN adds an accel/decel dwell ramp. Rev 1.0
`default_nettype none

module step_move_sched
  import step_move_sched_pkg::*;
#(
  parameter logic [15:0] T1MS     = 16'd49999,
  parameter logic [7:0]  STALL_MS = 8'd100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [c_step_w-1:0] cmd_steps,
  input  logic [3:0]          cmd_speed,
  input  logic                abort,
  input  logic [3:0]          phase_in,
  output logic                drv_start,
  output logic                drv_dir,
  output logic [3:0]          drv_speed,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [c_step_w-1:0] steps_left
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_prev_phase;
  logic [3:0]          r_speed;
  logic [3:0]          r_drv_speed;
  logic                r_drv_start;
  logic                r_drv_dir;
  logic                r_fault;
  logic [c_step_w-1:0] r_steps_left;
  logic                w_run;
  logic                w_step;
  logic                w_stall;
  logic                w_final;
  logic                w_accept;

  assign w_run    = (r_state == RUN);
  assign w_step   = (phase_in != r_prev_phase) && (phase_in != 4'b0000);
  assign w_accept = cmd_valid && (r_state == IDLE);
  // Leave RUN on the edge of the last step so drv_start drops the following cycle.
  assign w_final  = (r_steps_left == '0) || (w_step && (r_steps_left == c_step_w'(1)));

  step_stall_wdt #(
    .T1MS     (T1MS),
    .STALL_MS (STALL_MS)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .i_run   (w_run),
    .i_step  (w_step),
    .o_stall (w_stall)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = (r_steps_left != '0) ? RUN : FINISH;
      RUN:     if (abort || w_stall || w_final) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev_phase <= 4'b0000;
      r_speed      <= c_idle_dwell;
      r_drv_speed  <= c_idle_dwell;
      r_drv_start  <= 1'b0;
      r_drv_dir    <= 1'b0;
      r_fault      <= 1'b0;
      r_steps_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_phase <= phase_in;
      r_drv_start  <= (w_state_nxt == RUN);
      if (w_accept) begin
        r_drv_dir    <= cmd_dir;
        r_speed      <= cmd_speed;
        r_steps_left <= cmd_steps;
        r_fault      <= 1'b0;
      end
      // Abort wins over a coincident final step: the count is left untouched.
      if (w_run) begin
        if (abort || w_stall) begin
          r_fault <= 1'b1;
        end else if (w_step && (r_steps_left != '0)) begin
          r_steps_left <= r_steps_left - c_step_w'(1);
        end
      end
`ifdef RAMP_EN
      if (w_state_nxt != RUN) begin
        r_drv_speed <= c_idle_dwell;
      end else if (w_run && w_step) begin
        if (r_steps_left <= c_step_w'(c_idle_dwell - r_drv_speed)) begin
          if (r_drv_speed != c_idle_dwell) r_drv_speed <= r_drv_speed + 4'd1;
        end else if (r_drv_speed > r_speed) begin
          r_drv_speed <= r_drv_speed - 4'd1;
        end
      end
`else
      r_drv_speed <= (w_state_nxt == RUN) ? r_speed : c_idle_dwell;
`endif
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FINISH);
  assign drv_start  = r_drv_start;
  assign drv_dir    = r_drv_dir;
  assign drv_speed  = r_drv_speed;
  assign fault      = r_fault;
  assign steps_left = r_steps_left;

endmodule

`default_nettype wire

// File: tb/tb_step_move_sched.sv
// tb_step_move_sched -- table-driven moves with a done-time scoreboard and a phase-stepping driver model
// Rev 1.0
`default_nettype none

module tb_step_move_sched;

  typedef struct {
    logic        dir;
    logic [15:0] steps;
    logic [3:0]  speed;
    int          abort_after;
    logic [15:0] exp_left;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [15:0] left;
    logic        fault;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = 16'd0;
  logic [3:0]  cmd_speed = 4'd0;
  logic        abort = 1'b0;
  logic [3:0]  phase_in = 4'b0001;
  logic        cmd_ready, drv_start, drv_dir, busy, done, fault;
  logic [3:0]  drv_speed;
  logic [15:0] steps_left;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t sb[$];
  logic [3:0] spd_q[$];
  vec_t vecs[7];

  logic       freeze = 1'b0;
  int         div = 0;
  int         phase_changes = 0;
  logic       saw_start = 1'b0;
  logic [1:0] pidx = 2'd0;
  logic       prev_done = 1'b0;

  step_move_sched #(
    .T1MS     (16'd9),
    .STALL_MS (8'd2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_speed  (cmd_speed),
    .abort      (abort),
    .phase_in   (phase_in),
    .drv_start  (drv_start),
    .drv_dir    (drv_dir),
    .drv_speed  (drv_speed),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Stepper driver model: advance one coil phase every third cycle while enabled.
  always @(negedge clk) begin
    if (drv_start) saw_start = 1'b1;
    if (drv_start && !freeze) begin
      if (div == 2) begin
        div = 0;
        spd_q.push_back(drv_speed);
        pidx = drv_dir ? pidx + 2'd1 : pidx - 2'd1;
        phase_in = 4'b0001 << pidx;
        phase_changes++;
      end else begin
        div++;
      end
    end else begin
      div = 0;
    end
  end

  // Scoreboard: every done pulse retires the oldest outstanding command.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          note_timeout("done_unexpected");
        end else begin
          res_t e;
          e = sb.pop_front();
          check("done_steps_left", steps_left, e.left);
          check("done_fault", fault, e.fault);
        end
        check("done_one_cycle", prev_done, 0);
        check("done_start_low", drv_start, 0);
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic dir, input logic [15:0] steps, input logic [3:0] speed,
                       input logic [15:0] exp_left, input logic exp_fault);
    int t;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) note_timeout("cmd_ready_wait");
    cmd_dir   = dir;
    cmd_steps = steps;
    cmd_speed = speed;
    cmd_valid = 1'b1;
    sb.push_back('{exp_left, exp_fault});
    phase_changes = 0;
    spd_q.delete();
    saw_start = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("load_busy", busy, 1);
    check("load_dir", drv_dir, dir);
    check("load_start_low", drv_start, 0);
  endtask

  task automatic run_move(input vec_t v);
    int t;
    issue(v.dir, v.steps, v.speed, v.exp_left, v.exp_fault);
    if (v.abort_after >= 0) begin
      t = 0;
      while (!(drv_start && (steps_left == v.steps - 16'(v.abort_after))) && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) note_timeout("abort_point_wait");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_start_low", drv_start, 0);
      check("abort_fault", fault, 1);
    end
    t = 0;
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) note_timeout("done_wait");
    if (v.abort_after < 0) begin
      check("phase_changes", phase_changes, 32'(v.steps));
`ifndef RAMP_EN
      begin
        logic ok;
        ok = 1'b1;
        foreach (spd_q[k]) if (spd_q[k] !== v.speed) ok = 1'b0;
        check("run_speed", ok, 1);
      end
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    vec_t rv;
    vecs[0] = '{1'b1, 16'd4,  4'd2,  -1, 16'd0, 1'b0};
    vecs[1] = '{1'b0, 16'd5,  4'd7,  -1, 16'd0, 1'b0};
    vecs[2] = '{1'b1, 16'd10, 4'd3,   2, 16'd8, 1'b1};
    vecs[3] = '{1'b0, 16'd1,  4'd0,  -1, 16'd0, 1'b0};
    vecs[4] = '{1'b1, 16'd3,  4'd15,  0, 16'd3, 1'b1};
    vecs[5] = '{1'b0, 16'd6,  4'd9,  -1, 16'd0, 1'b0};
    vecs[6] = '{1'b1, 16'd7,  4'd4,  -1, 16'd0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_drv_start", drv_start, 0);
    check("rst_drv_dir", drv_dir, 0);
    check("rst_drv_speed", drv_speed, 4'hF);
    check("rst_steps_left", steps_left, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_move(vecs[i]);

    // Zero-step command with abort held: abort outside RUN must be ignored.
    abort = 1'b1;
    issue(1'b1, 16'd0, 4'd5, 16'd0, 1'b0);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b0;
    check("zero_done_latency", n, 2);
    check("zero_fault", fault, 0);
    @(negedge clk);
    check("zero_never_started", saw_start, 0);

    // Frozen phase feedback: stall must fire 20 cycles into RUN.
    freeze = 1'b1;
    issue(1'b1, 16'd5, 4'd1, 16'd5, 1'b1);
    n = 0;
    while (!drv_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) note_timeout("stall_run_wait");
    n = 0;
    while (!fault && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_latency_ok", (n >= 19 && n <= 21), 1);
    check("stall_start_low", drv_start, 0);
    freeze = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-move.
    issue(1'b0, 16'd8, 4'd6, 16'd0, 1'b0);
    n = 0;
    while (!(drv_start && steps_left == 16'd6) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) note_timeout("reset_point_wait");
    rst = 1'b1;
    #1;
    check("midrst_drv_start", drv_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_steps_left", steps_left, 0);
    check("midrst_drv_speed", drv_speed, 4'hF);
    check("midrst_drv_dir", drv_dir, 0);
    check("midrst_fault", fault, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1);
    run_move(vecs[6]);

`ifdef RAMP_EN
    rv = '{1'b1, 16'd20, 4'd12, -1, 16'd0, 1'b0};
    run_move(rv);
    check("ramp_events", spd_q.size(), 20);
    for (int i = 0; i < 20 && i < spd_q.size(); i++) begin
      logic [3:0] e;
      e = (i < 3) ? 4'(15 - i) : (i < 18) ? 4'd12 : 4'(12 + i - 17);
      check("ramp_speed", spd_q[i], e);
    end
`else
    rv = vecs[0];
    run_move(rv);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
